// File: rtl/hwpe_ctrl_periph_arbiter_if.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_periph_arbiter_if
//   Peripheral bus bundle for the HWPE control port (req/gnt request phase,
//   r_valid response phase). Every field is a flat vector carrying N_PORTS
//   lanes, so one definition serves the N-lane initiator side of the arbiter
//   (N_PORTS = N_MASTERS) and its single-lane target side (N_PORTS = 1).
//
//   Signals (per lane):
//     req      initiator -> target  request
//     add      initiator -> target  32-bit address
//     wen      initiator -> target  write-enable-low (1 = read)
//     be       initiator -> target  4-bit byte enable
//     data     initiator -> target  32-bit write data
//     id       initiator -> target  ID_WIDTH-bit transaction id
//     gnt      target -> initiator  request accepted
//     r_data   target -> initiator  32-bit response data
//     r_valid  target -> initiator  response valid
//     r_id     target -> initiator  ID_WIDTH-bit response id
//
//   Modports:
//     master  the side that issues requests
//     slave   the side that accepts requests and returns responses
// ---------------------------------------------------------------------------
interface hwpe_ctrl_periph_arbiter_if #(
  parameter int unsigned N_PORTS  = 1,
  parameter int unsigned ID_WIDTH = 2
) ();

  logic [N_PORTS-1:0]          req;
  logic [N_PORTS*32-1:0]       add;
  logic [N_PORTS-1:0]          wen;
  logic [N_PORTS*4-1:0]        be;
  logic [N_PORTS*32-1:0]       data;
  logic [N_PORTS*ID_WIDTH-1:0] id;
  logic [N_PORTS-1:0]          gnt;
  logic [N_PORTS*32-1:0]       r_data;
  logic [N_PORTS-1:0]          r_valid;
  logic [N_PORTS*ID_WIDTH-1:0] r_id;

  modport master (
    output req, add, wen, be, data, id,
    input  gnt, r_data, r_valid, r_id
  );

  modport slave (
    input  req, add, wen, be, data, id,
    output gnt, r_data, r_valid, r_id
  );

endinterface

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// ---------------------------------------------------------------------------
// hwpe_ctrl_periph_arbiter
//   Shares one HWPE peripheral target port among N_MASTERS initiators
//   (core, debug, DMA, ...). Requests are arbitrated round-robin; once a
//   master has been offered to the target without a grant, that master stays
//   locked onto the target until granted, so the target never sees a request
//   change underneath it. The request path is purely combinational (no added
//   latency). Grants are recorded in an in-order FIFO so each response is
//   routed back to the master whose request was granted first.
//
//   Ports:
//     clk_i    clock
//     rst_ni   asynchronous active-low reset
//     clear_i  synchronous clear of lock, round-robin pointer and FIFO
//     mst      N_MASTERS-lane bus, slave modport (initiators connect here)
//     slv      single-lane bus, master modport (HWPE register file target)
//
//   Response data and id are broadcast to every initiator; only r_valid is
//   steered, one-hot, to the originator.
// ---------------------------------------------------------------------------
module hwpe_ctrl_periph_arbiter #(
  parameter int unsigned N_MASTERS       = 4,
  parameter int unsigned ID_WIDTH        = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  hwpe_ctrl_periph_arbiter_if.slave   mst,
  hwpe_ctrl_periph_arbiter_if.master  slv
);

  localparam int unsigned IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Arbitration state
  state_e             state_r;
  state_e             state_s;
  logic [IDX_W-1:0]   locked_idx_r;
  logic [IDX_W-1:0]   locked_idx_s;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   rr_ptr_s;

  // Response-routing FIFO: holds the index of each granted master
  logic [IDX_W-1:0]   fifo_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               err_r;

  // Combinational datapath
  logic [IDX_W-1:0]   winner_s;
  logic [IDX_W-1:0]   sel_idx_s;
  logic [IDX_W-1:0]   head_idx_s;
  logic               sel_valid_s;
  logic               grant_s;
  logic               pop_s;
  logic               stray_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;

  // Next master index, wrapping at N_MASTERS (which need not be a power of 2).
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(N_MASTERS - 1)) begin
      idx_inc = '0;
    end else begin
      idx_inc = idx + IDX_W'(1);
    end
  endfunction

  // Next FIFO pointer, wrapping at MAX_OUTSTANDING.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // First requester found scanning cyclically from ptr; returns ptr when
  // nobody requests (the caller qualifies with the request bit itself).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]     ptr);
    logic        found;
    int unsigned cand;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N_MASTERS) begin
        cand = cand - N_MASTERS;
      end else begin
        cand = cand;
      end
      if (!found && req[IDX_W'(cand)]) begin
        rr_pick = IDX_W'(cand);
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // FIFO occupancy flags and the master owed the oldest response.
  always_comb begin
    fifo_full_s  = (count_r == CNT_W'(MAX_OUTSTANDING));
    fifo_empty_s = (count_r == CNT_W'(0));
    head_idx_s   = fifo_mem_r[rd_ptr_r];
  end

  // Round-robin winner among the current requesters.
  always_comb begin
    winner_s = rr_pick(mst.req, rr_ptr_r);
  end

  // Request offered to the target: a lock overrides the round-robin choice.
  // Nothing is offered while the FIFO is full (no slot to route the answer)
  // or during a clear, which must not be followed by a push.
  always_comb begin
    if (state_r == ST_LOCKED) begin
      sel_idx_s = locked_idx_r;
    end else begin
      sel_idx_s = winner_s;
    end
    sel_valid_s = mst.req[sel_idx_s] & ~fifo_full_s & ~clear_i;
    grant_s     = sel_valid_s & slv.gnt[0];
    // A response with nothing outstanding is dropped and only flagged.
    pop_s       = slv.r_valid[0] & ~fifo_empty_s & ~clear_i;
    stray_s     = slv.r_valid[0] & fifo_empty_s & ~clear_i;
  end

  // Next-state logic for the IDLE/LOCKED arbitration FSM and RR pointer.
  always_comb begin
    state_s      = state_r;
    locked_idx_s = locked_idx_r;
    rr_ptr_s     = rr_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          rr_ptr_s = idx_inc(winner_s);
        end else if (sel_valid_s) begin
          state_s      = ST_LOCKED;
          locked_idx_s = winner_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (!mst.req[locked_idx_r]) begin
          // Master withdrew a request it was locked on: release the lock,
          // leave the pointer where it was.
          state_s = ST_IDLE;
        end else if (grant_s) begin
          state_s  = ST_IDLE;
          rr_ptr_s = idx_inc(locked_idx_r);
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: mux the selected request to the target, steer grant and
  // response valid one-hot, broadcast response data/id.
  always_comb begin
    slv.req     = sel_valid_s;
    slv.add     = '0;
    slv.wen     = '0;
    slv.be      = '0;
    slv.data    = '0;
    slv.id      = '0;
    mst.gnt     = '0;
    mst.r_valid = '0;
    mst.r_data  = {N_MASTERS{slv.r_data[31:0]}};
    mst.r_id    = {N_MASTERS{slv.r_id[ID_WIDTH-1:0]}};
    if (sel_valid_s) begin
      slv.add  = mst.add[32'(sel_idx_s)*32'd32 +: 32];
      slv.wen  = mst.wen[sel_idx_s];
      slv.be   = mst.be[32'(sel_idx_s)*32'd4 +: 4];
      slv.data = mst.data[32'(sel_idx_s)*32'd32 +: 32];
      slv.id   = mst.id[32'(sel_idx_s)*ID_WIDTH +: ID_WIDTH];
    end else begin
      slv.add  = '0;
    end
    if (grant_s) begin
      mst.gnt[sel_idx_s] = 1'b1;
    end else begin
      mst.gnt = '0;
    end
    if (pop_s) begin
      mst.r_valid[head_idx_s] = 1'b1;
    end else begin
      mst.r_valid = '0;
    end
  end

  // State register: FSM state, locked master and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      locked_idx_r <= '0;
      rr_ptr_r     <= '0;
    end else if (clear_i) begin
      state_r      <= ST_IDLE;
      locked_idx_r <= '0;
      rr_ptr_r     <= '0;
    end else begin
      state_r      <= state_s;
      locked_idx_r <= locked_idx_s;
      rr_ptr_r     <= rr_ptr_s;
    end
  end

  // Response-routing FIFO: push on grant, pop on response, both may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (grant_s) begin
        fifo_mem_r[wr_ptr_r] <= sel_idx_s;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({grant_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky record of a response that arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (stray_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  hwpe_ctrl_periph_arbiter_chk #(
    .N_MASTERS       (N_MASTERS),
    .CNT_W           (CNT_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .gnt     (mst.gnt),
    .r_valid (mst.r_valid),
    .count   (count_r),
    .err     (err_r)
  );

endmodule

// ---------------------------------------------------------------------------
// hwpe_ctrl_periph_arbiter_chk
//   Simulation-only protocol properties of the arbiter: grants and response
//   valids are one-hot or zero, the FIFO never overfills, and a cover point
//   on the stray-response flag.
//   Ports: clk_i, rst_ni, gnt, r_valid (per master), count (FIFO occupancy),
//   err (sticky stray-response flag).
// ---------------------------------------------------------------------------
module hwpe_ctrl_periph_arbiter_chk #(
  parameter int unsigned N_MASTERS       = 4,
  parameter int unsigned CNT_W           = 3,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  input logic [N_MASTERS-1:0] gnt,
  input logic [N_MASTERS-1:0] r_valid,
  input logic [CNT_W-1:0]     count,
  input logic                 err
);

  gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt));

  r_valid_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_valid));

  count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  count <= CNT_W'(MAX_OUTSTANDING));

  stray_resp_c: cover property (@(posedge clk_i) disable iff (!rst_ni) err);

endmodule
